// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: result-select codes, load types, widths.
package writeback_stage_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int RA_W_DEF  = 5;
  localparam int CNT_W_DEF = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_load_align.sv
// Extracts and extends a byte/half/word from an aligned memory word and flags misalignment.
module writeback_stage_load_align
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_type,
  output logic [XLEN-1:0] o_value,
  output logic            o_misaligned
);
  logic [4:0]      w_shift;
  logic [XLEN-1:0] w_word;

  assign w_shift = {i_off, 3'b000};
  assign w_word  = i_data >> w_shift;

  // Unlisted type codes behave as LW so the datapath never produces X.
  always_comb begin
    o_value      = i_data;
    o_misaligned = 1'b0;
    case (i_type)
      LT_LB:  o_value = {{(XLEN-8){w_word[7]}}, w_word[7:0]};
      LT_LBU: o_value = {{(XLEN-8){1'b0}}, w_word[7:0]};
      LT_LH: begin
        o_value      = {{(XLEN-16){w_word[15]}}, w_word[15:0]};
        o_misaligned = i_off[0];
      end
      LT_LHU: begin
        o_value      = {{(XLEN-16){1'b0}}, w_word[15:0]};
        o_misaligned = i_off[0];
      end
      default: begin
        o_value      = i_data;
        o_misaligned = (i_off != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// WB pipeline stage: latches the MEM/WB bundle, selects the result and drives the RF write port.
// Handshake: a bundle transfers at posedge when in_valid & in_ready (in_ready = ~stall) and ~flush.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_reg_write,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_alu_res,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [2:0]       mem_load_type,
  input  logic [XLEN-1:0]  mem_pc,
  output logic [RA_W-1:0]  rf_A3,
  output logic [XLEN-1:0]  rf_WD,
  output logic             rf_RegWrite,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retired,
  output logic             misalign_err,
  output logic [XLEN-1:0]  misalign_pc
);
  logic             r_valid;
  logic             r_written;
  logic [RA_W-1:0]  r_rd;
  logic             r_reg_write;
  logic [1:0]       r_wb_sel;
  logic [XLEN-1:0]  r_alu_res;
  logic [XLEN-1:0]  r_load_data;
  logic [2:0]       r_load_type;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_retired;
  logic             r_mis_err;
  logic [XLEN-1:0]  r_mis_pc;

  logic [XLEN-1:0]  w_load_val;
  logic             w_load_mis;
  logic             w_mis;
  logic             w_first;
  logic [XLEN-1:0]  w_result;

  writeback_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .i_data       (r_load_data),
    .i_off        (r_alu_res[1:0]),
    .i_type       (r_load_type),
    .o_value      (w_load_val),
    .o_misaligned (w_load_mis)
  );

  // Misalignment only matters for instructions that actually select load data.
  assign w_mis   = (r_wb_sel == WB_SEL_LOAD) & w_load_mis;
  assign w_first = r_valid & ~r_written;

  always_comb begin
    w_result = r_alu_res;
    case (r_wb_sel)
      WB_SEL_LOAD: w_result = w_load_val;
      WB_SEL_PC4:  w_result = r_pc + XLEN'(4);
      default:     w_result = r_alu_res;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid     <= 1'b0;
      r_written   <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= '0;
      r_alu_res   <= '0;
      r_load_data <= '0;
      r_load_type <= '0;
      r_pc        <= '0;
      r_retired   <= '0;
      r_mis_err   <= 1'b0;
      r_mis_pc    <= '0;
    end else begin
      if (w_first) begin
        r_retired <= r_retired + CNT_W'(1);
        if (w_mis) begin
          r_mis_err <= 1'b1;
          if (!r_mis_err) r_mis_pc <= r_pc;
        end
      end
      if (stall) begin
        // Held entry: the written flag keeps it from writing or retiring twice.
        if (r_valid) r_written <= 1'b1;
      end else if (in_valid && !flush) begin
        r_valid     <= 1'b1;
        r_written   <= 1'b0;
        r_rd        <= mem_rd;
        r_reg_write <= mem_reg_write;
        r_wb_sel    <= mem_wb_sel;
        r_alu_res   <= mem_alu_res;
        r_load_data <= mem_load_data;
        r_load_type <= mem_load_type;
        r_pc        <= mem_pc;
      end else begin
        r_valid   <= 1'b0;
        r_written <= 1'b0;
      end
    end
  end

  assign in_ready     = ~stall;
  assign rf_A3        = r_rd;
  assign rf_WD        = w_result;
  assign rf_RegWrite  = w_first & r_reg_write & (r_rd != '0) & ~w_mis;
  assign fwd_valid    = rf_RegWrite;
  assign fwd_rd       = rf_A3;
  assign fwd_data     = rf_WD;
  assign retired      = r_retired;
  assign misalign_err = r_mis_err;
  assign misalign_pc  = r_mis_pc;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected RF writes are queued at drive time and popped on each write pulse.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic [RA_W-1:0]  mem_rd;
  logic             mem_reg_write;
  logic [1:0]       mem_wb_sel;
  logic [XLEN-1:0]  mem_alu_res;
  logic [XLEN-1:0]  mem_load_data;
  logic [2:0]       mem_load_type;
  logic [XLEN-1:0]  mem_pc;
  logic [RA_W-1:0]  rf_A3;
  logic [XLEN-1:0]  rf_WD;
  logic             rf_RegWrite;
  logic             fwd_valid;
  logic [RA_W-1:0]  fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] retired;
  logic             misalign_err;
  logic [XLEN-1:0]  misalign_pc;

  int checks   = 0;
  int failures = 0;
  int writes_seen = 0;
  logic [RA_W+XLEN-1:0] exp_q[$];
  logic [CNT_W-1:0]     exp_retired;
  int                   w0;

  writeback_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel), .mem_alu_res(mem_alu_res), .mem_load_data(mem_load_data),
    .mem_load_type(mem_load_type), .mem_pc(mem_pc), .rf_A3(rf_A3), .rf_WD(rf_WD),
    .rf_RegWrite(rf_RegWrite), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired(retired), .misalign_err(misalign_err), .misalign_pc(misalign_pc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0 && rf_RegWrite === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_A3, rf_WD}, 64'd0);
      end else begin
        logic [RA_W+XLEN-1:0] e;
        e = exp_q.pop_front();
        check("wb_rd", 64'(rf_A3), 64'(e[RA_W+XLEN-1:XLEN]));
        check("wb_data", 64'(rf_WD), 64'(e[XLEN-1:0]));
        check("fwd_tap", {fwd_valid, fwd_rd, fwd_data}, {1'b1, rf_A3, rf_WD});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Presents one bundle for one edge; returns 1 time unit after that transfer edge.
  task automatic send(input logic [RA_W-1:0] rd, input logic rw, input logic [1:0] sel,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld,
                      input logic [2:0] lt, input logic [XLEN-1:0] pc,
                      input logic exp_write, input logic [XLEN-1:0] exp_data);
    @(posedge CLK); #1;
    in_valid = 1'b1; mem_rd = rd; mem_reg_write = rw; mem_wb_sel = sel;
    mem_alu_res = alu; mem_load_data = ld; mem_load_type = lt; mem_pc = pc;
    if (exp_write) exp_q.push_back({rd, exp_data});
    exp_retired = exp_retired + 1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; stall = 1'b1; flush = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_wb_sel = '0; mem_alu_res = '0;
    mem_load_data = '0; mem_load_type = '0; mem_pc = '0;
    exp_retired = '0;
    idle(2);
    @(negedge CLK);
    check("rst_ready_stalled", 64'(in_ready), 64'd0);
    stall = 1'b0;
    @(negedge CLK);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", {rf_RegWrite, fwd_valid, rf_A3, rf_WD, misalign_err},
          64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_mis_pc", 64'(misalign_pc), 64'd0);
    RST = 1'b0;

    // ALU op: write visible one cycle after transfer, single pulse, retired=1.
    send(5'd5, 1'b1, WB_SEL_ALU, 32'h1234, 32'h0, LT_LW, 32'h0, 1'b1, 32'h1234);
    @(negedge CLK);
    check("alu_pulse", 64'(rf_RegWrite), 64'd1);
    @(negedge CLK);
    check("alu_pulse_end", 64'(rf_RegWrite), 64'd0);
    check("alu_retired", 64'(retired), 64'd1);

    // Load extraction.
    send(5'd6, 1'b1, WB_SEL_LOAD, 32'h3, 32'h80FF7F01, LT_LB,  32'h8, 1'b1, 32'hFFFFFF80);
    send(5'd7, 1'b1, WB_SEL_LOAD, 32'h3, 32'h80FF7F01, LT_LBU, 32'hC, 1'b1, 32'h00000080);
    send(5'd8, 1'b1, WB_SEL_LOAD, 32'h2, 32'h80FF7F01, LT_LHU, 32'h10, 1'b1, 32'h000080FF);
    send(5'd9, 1'b1, WB_SEL_LOAD, 32'h0, 32'h80FF7F01, LT_LH,  32'h14, 1'b1, 32'h00007F01);
    send(5'd10, 1'b1, WB_SEL_LOAD, 32'h1, 32'h80FF7F01, LT_LB, 32'h18, 1'b1, 32'h0000007F);
    send(5'd11, 1'b1, WB_SEL_LOAD, 32'h2, 32'h80FF7F01, LT_LH, 32'h1C, 1'b1, 32'hFFFF80FF);
    send(5'd12, 1'b1, WB_SEL_LOAD, 32'h0, 32'h80FF7F01, LT_LW, 32'h20, 1'b1, 32'h80FF7F01);

    // JAL link value and x0 write suppression.
    send(5'd1, 1'b1, WB_SEL_PC4, 32'h0, 32'h0, LT_LW, 32'h40, 1'b1, 32'h44);
    send(5'd0, 1'b1, WB_SEL_ALU, 32'hDEAD, 32'h0, LT_LW, 32'h44, 1'b0, 32'h0);
    send(5'd13, 1'b1, 2'b11, 32'h5555, 32'h0, LT_LW, 32'h48, 1'b1, 32'h5555);
    send(5'd14, 1'b0, WB_SEL_ALU, 32'h7777, 32'h0, LT_LW, 32'h4C, 1'b0, 32'h0);
    idle(2);
    check("retired_after_loads", 64'(retired), 64'(exp_retired));
    check("no_misalign_yet", 64'(misalign_err), 64'd0);

    // Misaligned loads: suppressed write, sticky flag, first PC kept.
    send(5'd15, 1'b1, WB_SEL_LOAD, 32'h2, 32'hFFFFFFFF, LT_LW, 32'h100, 1'b0, 32'h0);
    idle(2);
    check("mis_err", 64'(misalign_err), 64'd1);
    check("mis_pc", 64'(misalign_pc), 64'h100);
    send(5'd16, 1'b1, WB_SEL_LOAD, 32'h1, 32'hFFFFFFFF, LT_LH, 32'h200, 1'b0, 32'h0);
    idle(2);
    check("mis_pc_sticky", 64'(misalign_pc), 64'h100);
    check("mis_retired", 64'(retired), 64'(exp_retired));

    // Stall of 3 cycles: one write pulse, one retire, new input ignored.
    w0 = writes_seen;
    send(5'd17, 1'b1, WB_SEL_ALU, 32'hCAFE, 32'h0, LT_LW, 32'h300, 1'b1, 32'hCAFE);
    stall = 1'b1; in_valid = 1'b1; mem_rd = 5'd18; mem_alu_res = 32'hBAD0;
    @(negedge CLK);
    check("stall_ready", 64'(in_ready), 64'd0);
    idle(3);
    stall = 1'b0; in_valid = 1'b0;
    idle(2);
    check("stall_one_write", 64'(writes_seen - w0), 64'd1);
    check("stall_retired", 64'(retired), 64'(exp_retired));

    // Flush with in_valid: no transfer.
    w0 = writes_seen;
    @(posedge CLK); #1;
    in_valid = 1'b1; flush = 1'b1; mem_rd = 5'd19; mem_reg_write = 1'b1; mem_alu_res = 32'hF00D;
    @(posedge CLK); #1;
    in_valid = 1'b0; flush = 1'b0;
    idle(2);
    check("flush_no_write", 64'(writes_seen - w0), 64'd0);
    check("flush_retired", 64'(retired), 64'(exp_retired));

    // Reset during stall clears counter, sticky flag and outputs.
    send(5'd20, 1'b1, WB_SEL_ALU, 32'h1111, 32'h0, LT_LW, 32'h400, 1'b1, 32'h1111);
    stall = 1'b1;
    idle(2);
    RST = 1'b1;
    idle(1);
    @(negedge CLK);
    check("rst_stall_outputs", {rf_RegWrite, rf_A3, rf_WD, misalign_err}, 64'd0);
    check("rst_stall_retired", 64'(retired), 64'd0);
    check("rst_stall_mis_pc", 64'(misalign_pc), 64'd0);
    RST = 1'b0; stall = 1'b0;
    exp_retired = '0;

    // Counter wrap.
    idle(1);
    force dut.r_retired = 32'hFFFFFFFF;
    #1;
    release dut.r_retired;
    @(negedge CLK);
    check("wrap_preload", 64'(retired), 64'hFFFFFFFF);
    exp_retired = 32'hFFFFFFFF;
    send(5'd21, 1'b1, WB_SEL_ALU, 32'h2222, 32'h0, LT_LW, 32'h500, 1'b1, 32'h2222);
    idle(2);
    check("wrap_zero", 64'(retired), 64'(exp_retired));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
